// File: rtl/kmeans_pkg.sv
// Shared frame geometry, scan-state encoding and beat payload for the mask streamer and k_means.
package kmeans_pkg;

    localparam int unsigned WIDTH  = 320;
    localparam int unsigned HEIGHT = 180;
    localparam int unsigned XW     = 9;
    localparam int unsigned YW     = 8;
    localparam int unsigned AW     = 17;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        EOF,
        WAIT_DONE
    } state_e;

    typedef struct packed {
        logic          rd;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } beat_t;

endpackage

// File: rtl/pipeline.sv
// Fixed-depth register delay line with synchronous flush to a programmable reset word.
module pipeline #(
    parameter int unsigned   DW      = 1,
    parameter int unsigned   STAGES  = 1,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);

    logic [DW-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/mask_streamer.sv
// Streams a binary mask frame out of the frame buffer in raster order, one beat per cycle,
// with a flush beat closing each row and an end-of-frame pulse for the k_means core.
module mask_streamer #(
    parameter int unsigned WIDTH        = kmeans_pkg::WIDTH,
    parameter int unsigned HEIGHT       = kmeans_pkg::HEIGHT,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_ready_in,
    output logic [16:0] fb_addr_out,
    input  logic        fb_data_in,
    output logic [8:0]  x_out,
    output logic [7:0]  y_out,
    output logic        mask_out,
    output logic        new_frame_out,
    input  logic        km_done_in,
    output logic        busy_out,
    output logic [7:0]  dropped_out
);

    import kmeans_pkg::*;

    localparam int unsigned   CW        = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [XW-1:0] X_LAST    = XW'(WIDTH);
    localparam logic [XW-1:0] X_LASTRD  = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(HEIGHT - 1);
    localparam beat_t         BEAT_IDLE = '{rd: 1'b0, x: XW'(WIDTH + 1), y: YW'(HEIGHT)};

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] drain_q, drain_d;
    logic [7:0]    drop_q, drop_d;
    logic          pend_q, pend_d;
    logic          nf_q, nf_d;
    logic          busy_q, busy_d;
    beat_t         issue;
    beat_t         beat_out;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            drain_q <= '0;
            drop_q  <= '0;
            pend_q  <= 1'b0;
            nf_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
            drop_q  <= drop_d;
            pend_q  <= pend_d;
            nf_q    <= nf_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        drop_d  = drop_q;
        pend_d  = pend_q;
        nf_d    = 1'b0;

        // While busy, the first extra frame is parked; any beyond that are counted as lost.
        if (frame_ready_in && (state_q != IDLE)) begin
            if (!pend_q) begin
                pend_d = 1'b1;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (frame_ready_in || pend_q) begin
                    state_d = SCAN;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                    pend_d  = frame_ready_in && pend_q;
                end
            end
            SCAN: begin
                // Raster order makes the next read address always the previous one plus one.
                if (x_q == X_LAST) begin
                    if (y_q == Y_LAST) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end else begin
                        x_d    = '0;
                        y_d    = y_q + YW'(1);
                        addr_d = addr_q + AW'(1);
                    end
                end else begin
                    x_d = x_q + XW'(1);
                    if (x_q != X_LASTRD) begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            DRAIN: begin
                if (drain_q == CW'(READ_LATENCY - 1)) begin
                    state_d = EOF;
                    nf_d    = 1'b1;
                end else begin
                    drain_d = drain_q + CW'(1);
                end
            end
            EOF: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (km_done_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Beat issued this cycle; out-of-frame coordinates when nothing is being scanned.
    always_comb begin
        issue = BEAT_IDLE;
        if (state_q == SCAN) begin
            issue.rd = (x_q != X_LAST);
            issue.x  = x_q;
            issue.y  = y_q;
        end
    end

    pipeline #(
        .DW      ($bits(beat_t)),
        .STAGES  (READ_LATENCY),
        .RST_VAL (BEAT_IDLE)
    ) u_pipeline (
        .clk_i (clk_in),
        .rst_i (rst_in),
        .d_i   (issue),
        .q_o   (beat_out)
    );

    assign fb_addr_out   = addr_q;
    assign x_out         = beat_out.x;
    assign y_out         = beat_out.y;
    // Read data arrives in the same cycle as its delayed coordinates, so it is gated, not re-registered.
    assign mask_out      = beat_out.rd & fb_data_in;
    assign new_frame_out = nf_q;
    assign busy_out      = busy_q;
    assign dropped_out   = drop_q;

endmodule

// File: tb/tb_mask_streamer.sv
// Directed/random bench for mask_streamer on a reduced frame, with a modelled frame buffer.
module tb_mask_streamer;

    localparam int unsigned W  = 24;
    localparam int unsigned H  = 10;
    localparam int unsigned RL = 2;
    localparam int unsigned NB = H * (W + 1);
    localparam int unsigned MW = $clog2(W * H);

    logic        clk = 1'b0;
    logic        rst;
    logic        fr;
    logic        kd;
    logic        fbd;
    logic [16:0] addr;
    logic [8:0]  xo;
    logic [7:0]  yo;
    logic        mo;
    logic        nfo;
    logic        busy;
    logic [7:0]  drop;

    logic        mem [W*H];
    logic        rdp [RL];
    logic [16:0] ah  [RL];

    int total = 0;
    int bad   = 0;

    mask_streamer #(
        .WIDTH        (W),
        .HEIGHT       (H),
        .READ_LATENCY (RL)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .frame_ready_in (fr),
        .fb_addr_out    (addr),
        .fb_data_in     (fbd),
        .x_out          (xo),
        .y_out          (yo),
        .mask_out       (mo),
        .new_frame_out  (nfo),
        .km_done_in     (kd),
        .busy_out       (busy),
        .dropped_out    (drop)
    );

    always #5 clk = ~clk;

    // Frame buffer with RL-cycle read latency plus a matching history of issued addresses.
    always @(posedge clk) begin
        rdp[0] <= mem[MW'(addr)];
        ah[0]  <= addr;
        for (int i = 1; i < int'(RL); i++) begin
            rdp[i] <= rdp[i-1];
            ah[i]  <= ah[i-1];
        end
    end
    assign fbd = rdp[RL-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_mem();
        for (int i = 0; i < int'(W * H); i++) mem[i] = 1'($urandom);
    endtask

    task automatic chk_oof(input string tag);
        chk({tag, "_x"}, 32'(xo), 32'(W + 1));
        chk({tag, "_y"}, 32'(yo), 32'(H));
        chk({tag, "_mask"}, 32'(mo), 32'd0);
    endtask

    task automatic chk_reset_vals();
        chk_oof("rst");
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_nf", 32'(nfo), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
    endtask

    // Caller has just driven the trigger; lat = cycles until the first beat is visible.
    task automatic check_frame(input int lat, input int p1, input int p2, input int kd_at,
                               input int stop_at, output int ones, output int one_addr);
        int   ex, ey, ea;
        logic em;
        ones     = 0;
        one_addr = -1;
        for (int i = 1; i <= lat; i++) begin
            step();
            fr = 1'b0;
            kd = 1'b0;
            if (i < lat) begin
                chk_oof("lead");
                chk("lead_nf", 32'(nfo), 32'd0);
            end
        end
        for (int b = 0; b < int'(NB); b++) begin
            ex = b % int'(W + 1);
            ey = b / int'(W + 1);
            ea = ey * int'(W) + ex;
            em = (ex < int'(W)) ? mem[MW'(ea)] : 1'b0;
            chk("beat_x", 32'(xo), 32'(ex));
            chk("beat_y", 32'(yo), 32'(ey));
            chk("beat_mask", 32'(mo), 32'(em));
            chk("beat_nf", 32'(nfo), 32'd0);
            chk("beat_busy", 32'(busy), 32'd1);
            if (ex < int'(W)) chk("beat_addr", 32'(ah[RL-1]), 32'(ea));
            if (mo === 1'b1) begin
                ones++;
                one_addr = int'(ah[RL-1]);
            end
            if (b == stop_at) return;
            fr = (b == p1) || (b == p2);
            kd = (b == kd_at);
            step();
            fr = 1'b0;
            kd = 1'b0;
        end
        chk("eof_nf", 32'(nfo), 32'd1);
        chk_oof("eof");
        step();
        chk("post_eof_nf", 32'(nfo), 32'd0);
        chk("post_eof_busy", 32'(busy), 32'd1);
    endtask

    // From the cycle after EOF: km_done arrives 5 cycles after EOF, then idle.
    task automatic finish_frame();
        for (int i = 0; i < 4; i++) begin
            chk("wait_busy", 32'(busy), 32'd1);
            step();
        end
        kd = 1'b1;
        step();
        kd = 1'b0;
        chk("done_idle", 32'(busy), 32'd0);
        chk("done_nf", 32'(nfo), 32'd0);
        step();
        chk("done_stays_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int ones;
        int oaddr;
        rst = 1'b1;
        fr  = 1'b0;
        kd  = 1'b0;
        for (int i = 0; i < int'(W * H); i++) mem[i] = 1'b0;
        repeat (3) step();
        chk_reset_vals();
        rst = 1'b0;
        step();

        // All-zero frame.
        fr = 1'b1;
        check_frame(3, -1, -1, -1, -1, ones, oaddr);
        chk("zero_ones", 32'(ones), 32'd0);
        finish_frame();

        // Single set bit.
        mem[7*W+13] = 1'b1;
        fr = 1'b1;
        check_frame(3, -1, -1, -1, -1, ones, oaddr);
        chk("single_ones", 32'(ones), 32'd1);
        chk("single_addr", 32'(oaddr), 32'(7 * W + 13));
        finish_frame();

        // Random frame with two extra frame_ready pulses and a stray km_done mid-scan.
        rand_mem();
        fr = 1'b1;
        check_frame(3, 20, 60, 30, -1, ones, oaddr);
        chk("drop_one", 32'(drop), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("kd_ignored_busy", 32'(busy), 32'd1);
            step();
        end
        rand_mem();
        kd = 1'b1;
        check_frame(4, -1, -1, -1, -1, ones, oaddr);
        chk("drop_kept", 32'(drop), 32'd1);

        // frame_ready and km_done together in WAIT_DONE.
        step();
        rand_mem();
        fr = 1'b1;
        kd = 1'b1;
        check_frame(4, -1, -1, -1, -1, ones, oaddr);
        chk("drop_same", 32'(drop), 32'd1);

        // Lost-frame counter saturates.
        for (int i = 0; i < 300; i++) begin
            fr = 1'b1;
            step();
            fr = 1'b0;
            step();
        end
        chk("drop_sat", 32'(drop), 32'd255);
        chk("sat_busy", 32'(busy), 32'd1);

        // Reset in the middle of the frame.
        rand_mem();
        kd = 1'b1;
        check_frame(4, -1, -1, -1, int'((H / 2) * (W + 1) + 5), ones, oaddr);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals();
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_rst_idle", 32'(busy), 32'd0);
            chk("post_rst_nf", 32'(nfo), 32'd0);
        end
        rand_mem();
        fr = 1'b1;
        check_frame(3, -1, -1, -1, -1, ones, oaddr);
        finish_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
